// File: rtl/stdp_weight_update_sched.sv
// Round-robin scheduler that shares one STDP weight-update engine among
// num_syn synapse requesters. A granted update is written back through a
// one-hot register enable (active) and a shared write-data bus (wdata).
// Every output is registered; a grant costs one IDLE cycle plus one WRITE cycle.
module stdp_weight_update_sched #(
    parameter int num_syn      = 8,
    parameter int weight_width = 8,
    parameter int step         = 4,
    parameter int w_max        = 255,
    parameter int w_min        = 0
) (
    input  logic                             clk,
    input  logic                             reset,      // async, active-low
    input  logic                             enable,
    input  logic [num_syn-1:0]               req,
    input  logic [num_syn-1:0]               dir,
    input  logic [num_syn*weight_width-1:0]  weight_in,
    output logic [num_syn-1:0]               gnt,
    output logic [num_syn-1:0]               active,
    output logic [weight_width-1:0]          wdata,
    output logic                             busy
);

    localparam int idx_w = (num_syn > 1) ? $clog2(num_syn) : 1;
    localparam int ext_w = weight_width + 1;

    localparam logic [ext_w-1:0] step_e = ext_w'(step);
    localparam logic [ext_w-1:0] max_e  = ext_w'(w_max);
    localparam logic [ext_w-1:0] min_e  = ext_w'(w_min);
    localparam logic [idx_w-1:0] last_idx = idx_w'(num_syn - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [idx_w-1:0]        rr_ptr_q, rr_ptr_d;
    logic [idx_w-1:0]        sel_q, sel_d;
    logic [num_syn-1:0]      onehot_q, onehot_d;
    logic [weight_width-1:0] wdata_q, wdata_d;
    logic                    busy_q, busy_d;

    // Arbiter results and the new weight for the candidate winner.
    logic                    found;
    logic [idx_w-1:0]        pick;
    int                      scan_idx;
    logic [ext_w-1:0]        w_ext;
    logic [ext_w-1:0]        raw_ext;
    logic [ext_w-1:0]        nw_ext;

    // Round-robin search: first requester at or after rr_ptr, wrapping at num_syn.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        found    = 1'b0;
        pick     = rr_ptr_q;
        scan_idx = 0;
        for (int off = 0; off < num_syn; off++) begin
            scan_idx = int'(rr_ptr_q) + off;
            if (scan_idx >= num_syn) begin
                scan_idx = scan_idx - num_syn;
            end
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = idx_w'(scan_idx);
            end
        end
    end

    // Saturating +/- step on the selected weight, one bit wider than the weight.
    always_comb begin
        w_ext   = {1'b0, weight_in[pick*weight_width +: weight_width]};
        raw_ext = '0;
        nw_ext  = '0;
        if (dir[pick]) begin
            // w + step >= w_max is the same test as w >= w_max - step, but
            // cannot wrap when step exceeds w_max.
            raw_ext = (w_ext + step_e >= max_e) ? max_e : w_ext + step_e;
        end else begin
            raw_ext = (w_ext <= min_e + step_e) ? min_e : w_ext - step_e;
        end
        // Out-of-range starting weights can still land outside the window.
        nw_ext = raw_ext;
        if (nw_ext > max_e) begin
            nw_ext = max_e;
        end
        if (nw_ext < min_e) begin
            nw_ext = min_e;
        end
    end

    // Next-state and registered-output decode for the IDLE/WRITE FSM.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        onehot_d = '0;
        wdata_d  = '0;
        busy_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && found) begin
                    sel_d           = pick;
                    onehot_d[pick]  = 1'b1;
                    wdata_d         = weight_width'(nw_ext);
                    busy_d          = 1'b1;
                    state_d         = S_WRITE;
                end
            end
            S_WRITE: begin
                // The winner moves to the back of the queue for the next search.
                rr_ptr_d = (sel_q == last_idx) ? '0 : sel_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            onehot_q <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    // The grant pulse and the register enable are the same one-hot event.
    assign gnt    = onehot_q;
    assign active = onehot_q;
    assign wdata  = wdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_stdp_weight_update_sched.sv
// Bench for stdp_weight_update_sched: directed boundary cases plus random
// traffic, checked by a scoreboard fed from a plain-arithmetic reference model.
module tb_stdp_weight_update_sched;

    localparam int N      = 8;
    localparam int WW     = 8;
    localparam int STEP   = 4;
    localparam int W_MAX  = 255;
    localparam int W_MIN  = 0;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    req;
    logic [N-1:0]    dir;
    logic [N*WW-1:0] weight_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    active;
    logic [WW-1:0]   wdata;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;
    int rr_model    = 0;

    typedef struct {
        int idx;
        int nw;
    } exp_t;

    exp_t sb[$];

    stdp_weight_update_sched #(
        .num_syn     (N),
        .weight_width(WW),
        .step        (STEP),
        .w_max       (W_MAX),
        .w_min       (W_MIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .dir      (dir),
        .weight_in(weight_in),
        .gnt      (gnt),
        .active   (active),
        .wdata    (wdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: step the weight, then saturate into [W_MIN, W_MAX].
    function automatic int model_nw(input int w, input bit d);
        int r;
        r = d ? w + STEP : w - STEP;
        if (r > W_MAX) r = W_MAX;
        if (r < W_MIN) r = W_MIN;
        return r;
    endfunction

    // Reference: first requester at or after the pointer, circularly.
    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (r[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic int weight_of(input logic [N*WW-1:0] wv, input int i);
        return int'(wv[i*WW +: WW]);
    endfunction

    function automatic logic [WW-1:0] rand_weight();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return WW'($urandom_range(0, 2 * STEP));
        if (k == 1) return WW'($urandom_range(W_MAX - 2 * STEP, W_MAX));
        return WW'($urandom);
    endfunction

    // Monitor: whenever the DUT presents a write, it must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (gnt != '0 || active != '0 || busy) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", int'(gnt), 0);
            end else begin
                e = sb.pop_front();
                check("gnt", int'(gnt), 1 << e.idx);
                check("active", int'(active), 1 << e.idx);
                check("wdata", int'(wdata), e.nw);
                check("busy", int'(busy), 1);
            end
        end
    end

    // One request set, served to its grant; the winner drops its request.
    task automatic do_txn(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N*WW-1:0] wv);
        exp_t e;
        int   cyc;
        @(negedge clk);
        weight_in = wv;
        e.idx = model_pick(r, rr_model);
        e.nw  = model_nw(weight_of(wv, e.idx), d[e.idx]);
        sb.push_back(e);
        req = r;
        dir = d;
        @(posedge clk);
        #1;
        // Weights changing after sampling must not affect the in-flight write.
        weight_in = {$urandom, $urandom};
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gnt == '0 && cyc < 10);
        check("grant_latency", cyc, 1);
        req      = '0;
        rr_model = (e.idx + 1) % N;
        @(negedge clk);
        check("post_write_quiet", int'({gnt, active, wdata, busy}), 0);
    endtask

    initial begin
        logic [N*WW-1:0] wv;
        int              cnt;
        int              cyc;
        int              last;
        exp_t            e;

        // 1. Reset held with every requester asking: outputs stay quiet.
        reset     = 1'b0;
        enable    = 1'b1;
        req       = '1;
        dir       = '0;
        weight_in = '0;
        repeat (4) @(negedge clk);
        check("reset_gnt", int'(gnt), 0);
        check("reset_active", int'(active), 0);
        check("reset_wdata", int'(wdata), 0);
        check("reset_busy", int'(busy), 0);
        req   = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset_busy", int'(busy), 0);
        check("idle_after_reset_gnt", int'(gnt), 0);

        // 2. Single potentiation: synapse 3, weight 100.
        wv = '0;
        wv[3*WW +: WW] = 8'd100;
        do_txn(8'h08, 8'h08, wv);

        // 3. Saturation and ordinary depression.
        wv = '0;
        wv[0*WW +: WW] = 8'd253;
        do_txn(8'h01, 8'h01, wv);
        wv = '0;
        wv[1*WW +: WW] = 8'd2;
        do_txn(8'h02, 8'h00, wv);
        wv = '0;
        wv[6*WW +: WW] = 8'd50;
        do_txn(8'h40, 8'h00, wv);

        // 5. enable low freezes arbitration; raising it grants synapse 5.
        @(negedge clk);
        enable = 1'b0;
        req    = 8'h20;
        dir    = 8'h20;
        wv     = '0;
        wv[5*WW +: WW] = 8'd77;
        weight_in = wv;
        repeat (10) begin
            @(negedge clk);
            check("frozen_gnt", int'(gnt), 0);
            check("frozen_busy", int'(busy), 0);
        end
        e.idx = model_pick(8'h20, rr_model);
        e.nw  = model_nw(77, 1'b1);
        sb.push_back(e);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("enable_resume_gnt", int'(gnt), 8'h20);
        @(negedge clk);
        req      = '0;
        rr_model = (e.idx + 1) % N;
        @(negedge clk);

        // 6. Asynchronous reset in the middle of a write to synapse 2.
        wv = {$urandom, $urandom};
        @(negedge clk);
        weight_in = wv;
        e.idx = model_pick(8'h04, rr_model);
        e.nw  = model_nw(weight_of(wv, 2), 1'b0);
        sb.push_back(e);
        req = 8'h04;
        dir = 8'h00;
        @(negedge clk);
        check("pre_reset_active", int'(active), 8'h04);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_active", int'(active), 0);
        check("async_reset_gnt", int'(gnt), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_wdata", int'(wdata), 0);
        req = '0;
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        rr_model = 0;

        // 4. All requesters held: grants rotate 0..7,0 on every second cycle.
        @(negedge clk);
        wv = {$urandom, $urandom};
        weight_in = wv;
        dir = N'($urandom);
        for (int k = 0; k < N + 1; k++) begin
            e.idx = model_pick('1, rr_model);
            e.nw  = model_nw(weight_of(wv, e.idx), dir[e.idx]);
            sb.push_back(e);
            rr_model = (e.idx + 1) % N;
        end
        req  = '1;
        cnt  = 0;
        cyc  = 0;
        last = 0;
        while (cnt < N + 1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0) begin
                if (cnt > 0) check("rr_spacing", cyc - last, 2);
                last = cyc;
                cnt++;
                if (cnt == N + 1) req = '0;
            end
        end
        req = '0;
        check("rr_grant_count", cnt, N + 1);
        @(negedge clk);

        // Random traffic with near-bound weights mixed in.
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < N; i++) wv[i*WW +: WW] = rand_weight();
            do_txn(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), wv);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
